// File: rtl/lfsr_keystream_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lfsr_keystream_gen : Fibonacci LFSR keystream packed into valid/ready     |
// | words, first-generated bit in bit 0.                      Rev 1.0         |
// +--------------------------------------------------------------------------+
module lfsr_keystream_gen #(
  parameter int               WIDTH    = 64,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(64'h8000_0000_0000_000D),
  parameter int               OUT_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [WIDTH-1:0]    i_seed,
  input  logic                i_load,
  input  logic                i_ready,
  output logic                o_valid,
  output logic [OUT_BITS-1:0] o_word,
  output logic [WIDTH-1:0]    o_lfsr,
  output logic                o_zero_seed
);

  localparam int           CW   = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(OUT_BITS - 1);

  logic [WIDTH-1:0]    lfsr_q,  lfsr_d;
  logic [CW-1:0]       cnt_q,   cnt_d;
  logic [OUT_BITS-1:0] acc_q,   acc_d;
  logic [OUT_BITS-1:0] word_q,  word_d;
  logic                valid_q, valid_d;
  logic                zero_q,  zero_d;

  logic                w_adv;
  logic                w_fb;
  logic                w_bit;
  logic                w_seed_zero;
  logic [WIDTH-1:0]    w_seed;
  logic [OUT_BITS-1:0] w_acc_fill;

  // An all-zero state would lock the LFSR, so it is replaced by state 1.
  assign w_seed_zero = (i_seed == '0);
  assign w_seed      = w_seed_zero ? WIDTH'(1) : i_seed;

  assign w_adv = !(valid_q && !i_ready);
  assign w_fb  = ^(lfsr_q & TAPS);
  assign w_bit = lfsr_q[0];

  always_comb begin
    w_acc_fill        = acc_q;
    w_acc_fill[cnt_q] = w_bit;
  end

  always_comb begin
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    word_d  = word_q;
    valid_d = valid_q;
    zero_d  = zero_q;
    if (i_load) begin
      lfsr_d  = w_seed;
      cnt_d   = '0;
      acc_d   = '0;
      valid_d = 1'b0;
      zero_d  = w_seed_zero;
    end else if (w_adv) begin
      lfsr_d = {w_fb, lfsr_q[WIDTH-1:1]};
      if (cnt_q == LAST) begin
        word_d  = w_acc_fill;
        valid_d = 1'b1;
        cnt_d   = '0;
        acc_d   = '0;
      end else begin
        acc_d = w_acc_fill;
        cnt_d = cnt_q + 1'b1;
        if (i_ready) begin
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      lfsr_q  <= w_seed;
      cnt_q   <= '0;
      acc_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      zero_q  <= w_seed_zero;
    end else begin
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_word      = word_q;
  assign o_lfsr      = lfsr_q;
  assign o_zero_seed = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_keystream_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lfsr_keystream_gen : directed checks of lfsr_keystream_gen.            |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_lfsr_keystream_gen;

  localparam logic [31:0] T32 = 32'h8020_0003;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic        rst, load, ready;
  logic [63:0] seed;
  logic        valid, zero;
  logic [7:0]  word;
  logic [63:0] lfsr;

  // 32-bit instances, one word-wide and one bit-serial
  logic        rst32, load32, ready32;
  logic [31:0] seed32;
  logic        v_a, v_b, z_a, z_b;
  logic [31:0] word_a, lfsr_a, lfsr_b;
  logic [0:0]  word_b;

  int n_vec = 0;
  int n_err = 0;

  lfsr_keystream_gen u_dut (
    .i_clk(clk), .i_reset(rst), .i_seed(seed), .i_load(load), .i_ready(ready),
    .o_valid(valid), .o_word(word), .o_lfsr(lfsr), .o_zero_seed(zero)
  );

  lfsr_keystream_gen #(.WIDTH(32), .TAPS(T32), .OUT_BITS(32)) u_dut_w32 (
    .i_clk(clk), .i_reset(rst32), .i_seed(seed32), .i_load(load32), .i_ready(ready32),
    .o_valid(v_a), .o_word(word_a), .o_lfsr(lfsr_a), .o_zero_seed(z_a)
  );

  lfsr_keystream_gen #(.WIDTH(32), .TAPS(T32), .OUT_BITS(1)) u_dut_w1 (
    .i_clk(clk), .i_reset(rst32), .i_seed(seed32), .i_load(load32), .i_ready(ready32),
    .o_valid(v_b), .o_word(word_b), .o_lfsr(lfsr_b), .o_zero_seed(z_b)
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [31:0] s, ma, mb, ea, wa;
    logic        pa, pb, wb, eb;
    int          nxa, nxb;

    rst = 1'b1; load = 1'b0; ready = 1'b1; seed = 64'h1;
    rst32 = 1'b1; load32 = 1'b0; ready32 = 1'b0; seed32 = 32'h1;

    // reset state and first words from seed 1
    tick();
    check_val("rst_valid", valid, 1'b0);
    check_val("rst_word",  word,  8'h00);
    check_val("rst_lfsr",  lfsr,  64'h1);
    check_val("rst_zero",  zero,  1'b0);
    rst = 1'b0;
    tick_n(7);
    check_val("pre_valid", valid, 1'b0);
    tick();
    check_val("w1_valid", valid, 1'b1);
    check_val("w1_word",  word,  8'h01);
    check_val("w1_lfsr",  lfsr,  64'hFF00_0000_0000_0000);
    tick();
    check_val("xfer_clr", valid, 1'b0);
    tick_n(7);
    check_val("w2_valid", valid, 1'b1);
    check_val("w2_word",  word,  8'h00);
    check_val("w2_lfsr",  lfsr,  64'hFFFF_0000_0000_0000);

    // zero seed substitutes state 1
    rst = 1'b1; seed = 64'h0;
    tick();
    check_val("z_flag", zero, 1'b1);
    check_val("z_lfsr", lfsr, 64'h1);
    rst = 1'b0;
    tick_n(8);
    check_val("z_word",  word, 8'h01);
    check_val("z_lfsr8", lfsr, 64'hFF00_0000_0000_0000);
    check_val("z_stick", zero, 1'b1);
    load = 1'b1; seed = 64'h1;
    tick();
    load = 1'b0;
    check_val("ld_zero",  zero,  1'b0);
    check_val("ld_lfsr",  lfsr,  64'h1);
    check_val("ld_valid", valid, 1'b0);

    // backpressure holds word and state, then the stream resumes
    tick_n(7);
    ready = 1'b0;
    tick();
    check_val("bp_valid0", valid, 1'b1);
    tick_n(20);
    check_val("bp_valid", valid, 1'b1);
    check_val("bp_word",  word,  8'h01);
    check_val("bp_lfsr",  lfsr,  64'hFF00_0000_0000_0000);
    ready = 1'b1;
    tick();
    check_val("bp_accept", valid, 1'b0);
    tick_n(7);
    check_val("bp_next_valid", valid, 1'b1);
    check_val("bp_next_word",  word,  8'h00);
    check_val("bp_next_lfsr",  lfsr,  64'hFFFF_0000_0000_0000);

    // load discards a pending word
    ready = 1'b0;
    tick();
    load = 1'b1; seed = 64'h0123_4567_89AB_CDEF;
    tick();
    load = 1'b0;
    check_val("ldp_valid", valid, 1'b0);
    check_val("ldp_lfsr",  lfsr,  64'h0123_4567_89AB_CDEF);
    ready = 1'b1;
    tick_n(8);
    check_val("ldp_word",  word,  8'hEF);
    check_val("ldp_lfsrl", lfsr[55:0], 56'h01_2345_6789_ABCD);

    // load in the middle of a word (cnt=5)
    tick_n(5);
    load = 1'b1; seed = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    load = 1'b0;
    check_val("ldm_valid", valid, 1'b0);
    check_val("ldm_lfsr",  lfsr,  64'hDEAD_BEEF_CAFE_F00D);
    tick_n(7);
    check_val("ldm_pre",   valid, 1'b0);
    tick();
    check_val("ldm_vld",   valid, 1'b1);
    check_val("ldm_word",  word,  8'h0D);
    check_val("ldm_lfsrl", lfsr[55:0], 56'hDE_ADBE_EFCA_FEF0);

    // reset while a word is pending, held so the seed is re-sampled
    ready = 1'b0;
    rst = 1'b1; seed = 64'h5555_AAAA_1234_0F0F;
    tick();
    check_val("rp_valid", valid, 1'b0);
    check_val("rp_word",  word,  8'h00);
    check_val("rp_lfsr",  lfsr,  64'h5555_AAAA_1234_0F0F);
    seed = 64'h0BAD_F00D_0000_1111;
    tick();
    check_val("rh_lfsr", lfsr, 64'h0BAD_F00D_0000_1111);

    // reset wins over load
    load = 1'b1; seed = 64'h0;
    tick();
    check_val("pri_lfsr", lfsr, 64'h1);
    check_val("pri_zero", zero, 1'b1);
    rst = 1'b0; load = 1'b0;

    // 32-bit instances: random seed and random ready against a bit-serial model
    s = $urandom;
    if (s == 32'h0) s = 32'h1;
    seed32 = s;
    tick();
    rst32 = 1'b0;
    check_val("w32_seed", lfsr_a, s);
    check_val("w32_zero", z_a, 1'b0);
    check_val("w1_seed",  lfsr_b, s);
    ma = s; mb = s; nxa = 0; nxb = 0;
    for (int c = 0; c < 3000; c++) begin
      ready32 = 1'($urandom_range(0, 1));
      pa = v_a && ready32; wa = word_a;
      pb = v_b && ready32; wb = word_b[0];
      tick();
      if (pa) begin
        for (int k = 0; k < 32; k++) begin
          ea[k] = ma[0];
          ma = {^(ma & T32), ma[31:1]};
        end
        check_val("w32_word", wa, ea);
        nxa++;
      end
      if (pb) begin
        eb = mb[0];
        mb = {^(mb & T32), mb[31:1]};
        check_val("w1_bit", wb, eb);
        nxb++;
      end
    end
    check_val("w32_count", nxa >= 20, 1'b1);
    check_val("w1_count",  nxb >= 600, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
